ex_mem_stage: RTL and testbench

Execute-to-memory pipeline register for the 16-bit WISC datapath, sitting directly downstream of the execute-stage ALU (ADD/SUB/XOR/RED/shift/PADDSB units). Each cycle it captures the ALU result and the instruction's control bits into the EX/MEM register. It owns the architectural Z/V/N flag register and updates it per opcode. It also handles stall, flush and HLT, and keeps two wrapping performance counters.

---
 rtl/wisc_pkg.sv | 46 ++++
 rtl/ex_mem_stage_flag_reg.sv | 50 +++++
 rtl/ex_mem_stage.sv | 99 +++++++++
 tb/tb_ex_mem_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wisc_pkg
// Brief    : Shared WISC datapath widths, opcodes and flag-update classes.
// Revision : 1.0
// ============================================================================
package wisc_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_Z    = 2'd1,
        FC_ZVN  = 2'd2
    } flag_class_e;

    function automatic flag_class_e flag_class(input logic [3:0] op);
        flag_class_e fc;
        case (op)
            OP_ADD, OP_SUB:                 fc = FC_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z;
            default:                        fc = FC_NONE;
        endcase
        return fc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_flag_reg.sv
`default_nettype none
// ============================================================================
// Module   : flag_reg
// Brief    : Architectural Z/V/N flags, updated per opcode class on accept.
// Revision : 1.0
// ============================================================================
module flag_reg #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] result,
    input  logic          ovfl,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n
);
    import wisc_pkg::*;

    flag_class_e fc;
    logic        res_zero;

    assign fc       = flag_class(opcode);
    assign res_zero = (result == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (acc) begin
            case (fc)
                FC_ZVN: begin
                    flag_z <= res_zero;
                    flag_v <= ovfl;
                    flag_n <= result[DW-1];
                end
                FC_Z: begin
                    flag_z <= res_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register with flags, halt latch and perf counters.
// Revision : 1.0
// ============================================================================
module ex_mem_stage #(
    parameter int DW = 16,
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_ovfl,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    output logic          mem_valid,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_regwrite,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          halted,
    output logic [CW-1:0] retired_cnt,
    output logic [CW-1:0] bubble_cnt
);
    import wisc_pkg::*;

    logic adv;
    logic acc;
    logic is_hlt;

    // Stall dominates flush: a flush raised during a stall only acts once stall drops.
    assign adv    = !stall;
    assign acc    = adv && ex_valid && !flush && !halted;
    assign is_hlt = (ex_opcode == OP_HLT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            halted         <= 1'b0;
            retired_cnt    <= '0;
            bubble_cnt     <= '0;
        end else if (acc) begin
            mem_valid      <= 1'b1;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            // HLT travels down the pipe as a valid slot with no side effects.
            mem_regwrite   <= ex_regwrite && !is_hlt;
            mem_memread    <= ex_memread  && !is_hlt;
            mem_memwrite   <= ex_memwrite && !is_hlt;
            if (is_hlt) begin
                halted <= 1'b1;
            end
            retired_cnt    <= retired_cnt + CW'(1);
        end else if (adv) begin
            mem_valid      <= 1'b0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            bubble_cnt     <= bubble_cnt + CW'(1);
        end
    end

    flag_reg #(
        .DW (DW)
    ) u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .acc    (acc),
        .opcode (ex_opcode),
        .result (ex_result),
        .ovfl   (ex_ovfl),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n)
    );

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Randomized, model-checked bench for the EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_result;
    logic          ex_ovfl;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          mem_valid;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          mem_regwrite;
    logic          mem_memread;
    logic          mem_memwrite;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;
    logic          halted;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] bubble_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    ex_mem_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_result      (ex_result),
        .ex_ovfl        (ex_ovfl),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .flag_z         (flag_z),
        .flag_v         (flag_v),
        .flag_n         (flag_n),
        .halted         (halted),
        .retired_cnt    (retired_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state, stepped once per rising edge
    bit        m_valid, m_rw, m_mr, m_mw, m_z, m_v, m_n, m_halt;
    bit [15:0] m_result, m_sd;
    bit [3:0]  m_rd;
    int        m_ret, m_bub;

    wire [75:0] dut_vec = {mem_valid, mem_result, mem_store_data, mem_rd,
                           mem_regwrite, mem_memread, mem_memwrite,
                           flag_z, flag_v, flag_n, halted, retired_cnt, bubble_cnt};

    function automatic logic [75:0] model_vec();
        return {m_valid, m_result, m_sd, m_rd, m_rw, m_mr, m_mw,
                m_z, m_v, m_n, m_halt, 16'(m_ret), 16'(m_bub)};
    endfunction

    function automatic void model_reset();
        {m_valid, m_rw, m_mr, m_mw, m_z, m_v, m_n, m_halt} = '0;
        m_result = '0;
        m_sd     = '0;
        m_rd     = '0;
        m_ret    = 0;
        m_bub    = 0;
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (stall) return;
        if (ex_valid && !flush && !m_halt) begin
            m_valid  = 1;
            m_result = ex_result;
            m_sd     = ex_store_data;
            m_rd     = ex_rd;
            m_rw     = ex_regwrite;
            m_mr     = ex_memread;
            m_mw     = ex_memwrite;
            if (ex_opcode == 4'd15) begin
                m_halt = 1;
                m_rw   = 0;
                m_mr   = 0;
                m_mw   = 0;
            end
            m_ret = (m_ret + 1) % 65536;
            if (ex_opcode == 4'd0 || ex_opcode == 4'd1) begin
                m_z = (ex_result == 16'd0);
                m_v = ex_ovfl;
                m_n = (ex_result >= 16'h8000);
            end else if (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
                         ex_opcode == 4'd5 || ex_opcode == 4'd6) begin
                m_z = (ex_result == 16'd0);
            end
        end else begin
            m_valid = 0;
            m_rw    = 0;
            m_mr    = 0;
            m_mw    = 0;
            m_bub   = (m_bub + 1) % 65536;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic ovfl);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_result     = res;
        ex_ovfl       = ovfl;
        ex_store_data = 16'($urandom);
        ex_rd         = 4'($urandom);
        ex_regwrite   = 1'($urandom);
        ex_memread    = 1'($urandom);
        ex_memwrite   = 1'($urandom);
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_reset();
        idle();
        #2 rst = 1'b1;
        model_reset();
        tick();
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        drive(4'd0, 16'd0, 1'b0);
        ex_valid = 1'b0;
        model_reset();
        tick();
        tests_run++;
        if (dut_vec !== 76'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 0", dut_vec);
        end
        #2 rst = 1'b0;
        tests_run++;
        if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL reset_release: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_sat_add();
        drive(4'd0, 16'h7FFF, 1'b1);
        tick();
        tests_run++;
        if ({mem_result, flag_z, flag_v, flag_n, retired_cnt} !== {16'h7FFF, 3'b010, 16'd1}) begin
            tests_failed++;
            $display("FAIL sat_add: got res=%h zvn=%b%b%b ret=%0d expected res=7fff zvn=010 ret=1",
                     mem_result, flag_z, flag_v, flag_n, retired_cnt);
        end
        tests_run++;
        if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL sat_add_model: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_xor_paddsb();
        bit v0, n0;
        drive(4'd2, 16'h0000, 1'b1);
        tick();
        v0 = m_v;
        n0 = m_n;
        tests_run++;
        if (flag_z !== 1'b1 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL xor_zero: got z=%b vec=%h expected z=1 vec=%h", flag_z, dut_vec, model_vec());
        end
        drive(4'd7, 16'h8000, 1'b1);
        tick();
        tests_run++;
        if ({flag_z, flag_v, flag_n} !== {1'b1, v0, n0} || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL paddsb_hold: got zvn=%b%b%b expected zvn=1%b%b",
                     flag_z, flag_v, flag_n, v0, n0);
        end
    endtask

    task automatic test_stall_flush();
        logic [75:0] hold;
        hold = model_vec();
        drive(4'd1, 16'h0000, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            tests_run++;
            if (dut_vec !== hold) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, dut_vec, hold);
            end
        end
        stall = 1'b0;
        flush = 1'b1;
        tick();
        tests_run++;
        if (mem_valid !== 1'b0 || {flag_z, flag_v, flag_n} !== hold[35:33] ||
            bubble_cnt !== hold[15:0] + 16'd1) begin
            tests_failed++;
            $display("FAIL flush_bubble: got valid=%b zvn=%b%b%b bub=%0d expected valid=0 zvn=%b bub=%0d",
                     mem_valid, flag_z, flag_v, flag_n, bubble_cnt, hold[35:33], hold[15:0] + 16'd1);
        end
        flush = 1'b0;
    endtask

    task automatic test_hlt();
        int r0, b0;
        drive(4'd15, 16'h0000, 1'b1);
        ex_regwrite = 1'b1;
        ex_memwrite = 1'b1;
        tick();
        tests_run++;
        if ({halted, mem_valid, mem_regwrite, mem_memwrite} !== 4'b1100 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL hlt_accept: got halt=%b valid=%b rw=%b mw=%b expected 1 1 0 0",
                     halted, mem_valid, mem_regwrite, mem_memwrite);
        end
        r0 = m_ret;
        b0 = m_bub;
        for (int i = 0; i < 4; i++) begin
            drive(4'd0, 16'h0000, 1'b1);
            ex_regwrite = 1'b1;
            tick();
            tests_run++;
            if (mem_valid !== 1'b0 || mem_regwrite !== 1'b0) begin
                tests_failed++;
                $display("FAIL hlt_block[%0d]: got valid=%b rw=%b expected 0 0", i, mem_valid, mem_regwrite);
            end
        end
        tests_run++;
        if (retired_cnt !== 16'(r0) || bubble_cnt !== 16'(b0 + 4) || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL hlt_counters: got ret=%0d bub=%0d expected ret=%0d bub=%0d",
                     retired_cnt, bubble_cnt, r0, b0 + 4);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 149) == 0) op = 4'd15;
            drive(op, ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), 1'($urandom));
            ex_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 6) == 0);
            tick();
            tests_run++;
            if (dut_vec !== model_vec()) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, model_vec());
                errs++;
            end
        end
        idle();
    endtask

    task automatic test_reset_populated();
        pulse_reset();
        drive(4'd0, 16'h1234, 1'b0);
        tick();
        idle();
        tests_run++;
        if (mem_result !== 16'h1234 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL preload: got res=%h expected 1234", mem_result);
        end
        stall = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (dut_vec !== 76'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0", dut_vec);
        end
        tick();
        stall = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(4'($urandom_range(0, 14)), 16'($urandom), 1'($urandom));
            tick();
        end
        tests_run++;
        if (retired_cnt !== 16'hFFFF || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL wrap_preload: got ret=%0d expected 65535", retired_cnt);
        end
        drive(4'd2, 16'h0001, 1'b0);
        tick();
        tests_run++;
        if (retired_cnt !== 16'd0 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL wrap: got ret=%0d expected 0", retired_cnt);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_sat_add();
        test_xor_paddsb();
        test_stall_flush();
        test_hlt();
        test_random();
        test_reset_populated();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
